fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-byte fetch engine: drives the instruction-memory address (addr_i), captures returned bytes (din_i),
//  and streams them in program order to the frontend over a valid/ready handshake with their PCs.
//  Loads the 6502 reset vector after reset. Supports redirect (branch/jump/interrupt) with full squash of stale bytes.
// PARAMETERS
//  FIFO_DEPTH    4         byte buffer entries (power of 2, >=2); also cap on buffered+in-flight bytes
//  RESET_VECTOR  16'hFFFC  address of reset-vector low byte; high byte at RESET_VECTOR+1
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  addr_i       out  16  instruction memory read address (memory is always-read, 1-cycle sync latency)
//  din_i        in   8   byte for the address driven on the previous cycle
//  instr        out  8   byte at FIFO head
//  instr_pc     out  16  address of instr
//  instr_valid  out  1   head entry valid
//  instr_ready  in   1   frontend accepts head this cycle (transfer = valid & ready)
//  redirect     in   1   squash and restart fetch at redirect_pc
//  redirect_pc  in   16  new fetch address
// BEHAVIOUR
//  Reset: state=VEC_LO, pc=0, FIFO empty, no in-flight read, instr_valid=0, instr=0, instr_pc=0, addr_i=RESET_VECTOR.
//  State machine (one step per cycle, except RUN):
//   VEC_LO: addr_i=RESET_VECTOR -> VEC_HI.
//   VEC_HI: addr_i=RESET_VECTOR+1; pc[7:0]<=din_i -> LOAD.
//   LOAD:   pc[15:8]<=din_i; addr_i=pc (don't-care) -> RUN.
//   RUN:    stays until rst.
//  redirect is ignored outside RUN.
//  RUN issue rule: issue when (fifo_count + inflight) < FIFO_DEPTH.
//   Here fifo_count is post-pop for this cycle.
//   Issue: addr_i=pc, pc<=pc+1 (16-bit wrap FFFF->0000), inflight<=1 tagged with pc.
//   No issue: addr_i holds pc, pc unchanged.
//  Return: cycle after an issue, din_i is pushed with its tag unless squashed.
//   Pushed entry is visible on instr/instr_valid the following cycle.
//   Issue-to-valid latency is 2 cycles; sustained throughput 1 byte/cycle with ready=1.
//  Pop: instr_valid & instr_ready removes head. Push and pop in the same cycle are both honoured.
//   Order is strictly preserved. Never overflow; never drop an unsquashed byte.
//  instr, instr_pc and instr_valid are registered/FIFO-head outputs. They do not depend combinationally on instr_ready.
//  Redirect (RUN, redirect=1):
//   - instr_valid forced 0 that cycle; no pop.
//   - FIFO cleared and any in-flight read marked squashed (its din_i next cycle is discarded).
//   - No issue in that cycle; pc<=redirect_pc.
//   - Next cycle addr_i=redirect_pc (issue subject to the normal rule, FIFO now empty).
//   - Back-to-back redirects: the last one wins.
//  rst mid-operation: overrides everything; returns to VEC_LO, FIFO/in-flight discarded.
// TESTING
//  Vector load: mem[FFFC]=00, mem[FFFD]=80, ready=1.
//   -> addr_i FFFC, FFFD, x, 8000, 8001...
//   -> instr_valid first high 5 cycles after rst drops, with instr_pc=8000; consecutive PCs thereafter.
//  Backpressure: ready=0 in RUN.
//   -> exactly 4 bytes buffered, addr_i frozen at base+4.
//   -> then ready=1 drains base..base+3 in order, with no gap before base+4.
//  Wrap: redirect_pc=FFFE, ready=1.
//   -> instr_pc sequence FFFE, FFFF, 0000, 0001 with matching memory bytes.
//  Redirect with full FIFO + in-flight: redirect_pc=1234.
//   -> no stale byte ever valid; next valid entry has instr_pc=1234, 3 cycles after redirect.
//  Simultaneous events: ready toggled randomly 50%, redirect asserted on cycles where valid&ready.
//   -> redirect-cycle handshake suppressed (valid=0).
//   -> scoreboard sees in-order, gap-free PCs per stream.
//  Reset mid-run: rst pulsed 1 cycle during streaming.
//   -> instr_valid=0 next cycle, addr_i=FFFC, vector sequence restarts.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction-byte fetch engine with reset-vector load, small
//             in-order byte FIFO and redirect squash.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] addr_i,
    input  logic [7:0]  din_i,
    output logic [7:0]  instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_occ_w = c_ptr_w + 2;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        LOAD   = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          pc_q, pc_d;
    logic                 inflight_q, inflight_d;
    logic [15:0]          tag_q, tag_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w:0]     count_q, count_d;
    logic [7:0]           data_q [FIFO_DEPTH];
    logic [7:0]           data_d [FIFO_DEPTH];
    logic [15:0]          epc_q  [FIFO_DEPTH];
    logic [15:0]          epc_d  [FIFO_DEPTH];

    logic                 w_run;
    logic                 w_redir;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_issue;
    logic [c_occ_w-1:0]   w_occ;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        data_d     = data_q;
        epc_d      = epc_q;
        addr_i     = RESET_VECTOR;

        w_run       = (state_q == RUN);
        w_redir     = w_run & redirect;
        instr       = data_q[rd_ptr_q];
        instr_pc    = epc_q[rd_ptr_q];
        instr_valid = (count_q != '0) & ~w_redir;
        w_pop       = instr_valid & instr_ready;
        w_push      = inflight_q & ~w_redir;
        // Occupancy after this cycle's pop, counting the byte still on its way back
        w_occ       = c_occ_w'(count_q) - c_occ_w'(w_pop) + c_occ_w'(inflight_q);
        w_issue     = w_run & ~w_redir & (w_occ < c_occ_w'(FIFO_DEPTH));

        case (state_q)
            VEC_LO: begin
                addr_i  = RESET_VECTOR;
                state_d = VEC_HI;
            end
            VEC_HI: begin
                addr_i  = RESET_VECTOR + 16'd1;
                pc_d    = {pc_q[15:8], din_i};
                state_d = LOAD;
            end
            LOAD: begin
                addr_i  = pc_q;
                pc_d    = {din_i, pc_q[7:0]};
                state_d = RUN;
            end
            default: begin
                addr_i  = pc_q;
            end
        endcase

        if (w_issue) begin
            pc_d       = pc_q + 16'd1;
            inflight_d = 1'b1;
            tag_d      = pc_q;
        end

        if (w_redir) begin
            // Dropping inflight_d and clearing the FIFO squashes every stale byte
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                data_d[wr_ptr_q] = din_i;
                epc_d[wr_ptr_q]  = tag_q;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (c_ptr_w+1)'(w_push) - (c_ptr_w+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= VEC_LO;
            pc_q       <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '{default: '0};
            epc_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            epc_q      <= epc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed self-checking bench for fetch_unit with a sync memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_i;
    logic [7:0]  din_i;
    logic [7:0]  instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_pc;
    logic [15:0] base;
    logic [15:0] rpc;

    fetch_unit #(
        .FIFO_DEPTH   (4),
        .RESET_VECTOR (16'hFFFC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (addr_i),
        .din_i       (din_i),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        if (a == 16'hFFFC)      return 8'h00;
        else if (a == 16'hFFFD) return 8'h80;
        else                    return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk) din_i <= mem_f(addr_i);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready held high: the head must be valid every cycle with consecutive PCs
    task automatic stream(input int n);
        instr_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_pc",    32'(instr_pc),    32'(exp_pc));
            chk("stream_byte",  32'(instr),       32'(mem_f(exp_pc)));
            exp_pc = exp_pc + 16'd1;
            tick();
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        exp_pc      = 16'h0000;
        rpc         = 16'h4000;
        repeat (3) tick();

        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr),       32'd0);
        chk("rst_pc",    32'(instr_pc),    32'd0);
        chk("rst_addr",  32'(addr_i),      32'hFFFC);

        // Vector load
        rst = 1'b0;
        instr_ready = 1'b1;
        chk("vec_lo_addr", 32'(addr_i), 32'hFFFC);
        tick();
        chk("vec_hi_addr", 32'(addr_i), 32'hFFFD);
        tick();
        tick();
        chk("run_addr0",  32'(addr_i),      32'h8000);
        chk("run_valid0", 32'(instr_valid), 32'd0);
        tick();
        chk("run_addr1",  32'(addr_i),      32'h8001);
        chk("run_valid1", 32'(instr_valid), 32'd0);
        tick();
        exp_pc = 16'h8000;
        stream(6);

        // Backpressure: four buffered bytes, fetch frozen at base+4
        instr_ready = 1'b0;
        base = exp_pc;
        repeat (6) tick();
        chk("bp_valid", 32'(instr_valid), 32'd1);
        chk("bp_head",  32'(instr_pc),    32'(base));
        chk("bp_addr",  32'(addr_i),      32'(base + 16'd4));
        stream(8);

        // Redirect to FFFE and wrap through 0000
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        #1;
        chk("wrap_redir_valid", 32'(instr_valid), 32'd0);
        tick();
        redirect = 1'b0;
        chk("wrap_addr",   32'(addr_i),      32'hFFFE);
        chk("wrap_gap1",   32'(instr_valid), 32'd0);
        tick();
        chk("wrap_gap2",   32'(instr_valid), 32'd0);
        tick();
        exp_pc = 16'hFFFE;
        stream(4);

        // Redirect with buffered bytes plus one in flight
        instr_ready = 1'b0;
        repeat (2) tick();
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        #1;
        chk("sq_redir_valid", 32'(instr_valid), 32'd0);
        tick();
        redirect = 1'b0;
        chk("sq_gap1", 32'(instr_valid), 32'd0);
        tick();
        chk("sq_gap2", 32'(instr_valid), 32'd0);
        tick();
        chk("sq_valid", 32'(instr_valid), 32'd1);
        chk("sq_pc",    32'(instr_pc),    32'h1234);
        exp_pc = 16'h1234;
        stream(4);

        // Random ready with redirects landing on handshake cycles
        for (int i = 0; i < 300; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            if (instr_valid && instr_ready && ($urandom_range(0, 7) == 0)) begin
                redirect    = 1'b1;
                redirect_pc = rpc;
                #1;
                chk("rnd_redir_valid", 32'(instr_valid), 32'd0);
                exp_pc = rpc;
                rpc    = rpc + 16'h0101;
            end else if (instr_valid) begin
                chk("rnd_pc",   32'(instr_pc), 32'(exp_pc));
                chk("rnd_byte", 32'(instr),    32'(mem_f(exp_pc)));
                if (instr_ready) exp_pc = exp_pc + 16'd1;
            end
            tick();
            redirect = 1'b0;
        end

        // Reset pulse while streaming
        instr_ready = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_addr",  32'(addr_i),      32'hFFFC);
        tick();
        chk("mid_rst_addr1", 32'(addr_i),      32'hFFFD);
        tick();
        tick();
        chk("mid_rst_run",   32'(addr_i),      32'h8000);
        tick();
        tick();
        chk("mid_rst_valid1", 32'(instr_valid), 32'd1);
        chk("mid_rst_pc",     32'(instr_pc),    32'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
